// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that multiplexes byte requesters onto one UART
// transmitter. A grant holder may send a burst of bytes (up to MAX_BURST,
// or until its last byte); a holder that goes quiet for HOLD_CYCLES issue
// cycles loses the grant.
module uart_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 16,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic [7:0]           tx_byte,
  output logic                 tx_write_trigger,
  input  logic                 tx_ready
);

  typedef enum logic [2:0] {IDLE, ISSUE, TRIG, WAIT_BUSY, WAIT_IDLE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  burst_q, burst_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;

  // Requester vectors widened to the 4-requester maximum so the grant index
  // (always 2 bits) selects without width juggling.
  logic [3:0]  valid_pad, last_pad, ready_pad;
  logic [31:0] data_pad;

  logic [1:0]  pick;
  logic        found;
  logic        release_now;
  int          cand_sum;

  assign valid_pad = 4'(req_valid);
  assign last_pad  = 4'(req_last);
  assign data_pad  = 32'(req_data);

  assign req_ready = ready_pad[NUM_REQ-1:0];
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);
  assign tx_byte   = byte_q;

  // Counters stop at 0xFF instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next round-robin start point after the given holder.
  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    if (int'(v) + 1 >= NUM_REQ) return 2'd0;
    return v + 2'd1;
  endfunction

  // Round-robin search: first valid requester at or above rr_q, wrapping.
  always_comb begin
    found    = 1'b0;
    pick     = rr_q;
    cand_sum = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = int'(rr_q) + k;
      if (cand_sum >= NUM_REQ) cand_sum = cand_sum - NUM_REQ;
      if (!found && valid_pad[cand_sum[1:0]]) begin
        found = 1'b1;
        pick  = cand_sum[1:0];
      end
    end
  end

  // Next-state and output decode for the grant/transmit sequence.
  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    grant_d          = grant_q;
    burst_d          = burst_q;
    hold_d           = hold_q;
    byte_d           = byte_q;
    last_d           = last_q;
    ready_pad        = 4'b0000;
    tx_write_trigger = 1'b0;
    release_now      = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_ready && found) begin
          grant_d = pick;
          burst_d = 8'd0;
          hold_d  = 8'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ready_pad[grant_q] = tx_ready;
        if (tx_ready && valid_pad[grant_q]) begin
          byte_d  = data_pad[{grant_q, 3'b000} +: 8];
          last_d  = last_pad[grant_q];
          burst_d = sat_inc(burst_q);
          hold_d  = 8'd0;
          state_d = TRIG;
        end else if (!valid_pad[grant_q]) begin
          // Holder went quiet: count idle issue cycles, abort on the limit.
          hold_d = sat_inc(hold_q);
          if (sat_inc(hold_q) == 8'(HOLD_CYCLES)) release_now = 1'b1;
        end
      end
      TRIG: begin
        tx_write_trigger = 1'b1;
        state_d          = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_ready) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (tx_ready) begin
          if (last_q || burst_q == 8'(MAX_BURST)) release_now = 1'b1;
          else                                     state_d     = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (release_now) begin
      rr_d    = wrap_inc(grant_q);
      grant_d = 2'd0;
      state_d = IDLE;
    end
  end

  // State and datapath registers; reset abandons any in-flight byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= 2'd0;
      grant_q <= 2'd0;
      burst_q <= 8'd0;
      hold_q  <= 8'd0;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      hold_q  <= hold_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: requesters are byte queues, the UART is a
// behavioural stub, and expected transmit order comes from a packet-level
// round-robin model.
module tb_uart_tx_scheduler;

  localparam int MAXB = 4;
  localparam int HOLD = 5;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  tx_byte;
  logic        tx_write_trigger;
  logic        tx_ready;

  uart_tx_scheduler #(.NUM_REQ(4), .MAX_BURST(MAXB), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant_id(grant_id), .busy(busy),
    .tx_byte(tx_byte), .tx_write_trigger(tx_write_trigger), .tx_ready(tx_ready)
  );

  always #5 clock = ~clock;

  // Requester queues: {last, data}
  logic [8:0] rq [4][$];
  logic [1:0] trig_id [$];
  logic [7:0] trig_byte [$];
  logic [1:0] exp_id [$];
  logic [7:0] exp_byte [$];

  int total = 0;
  int passed = 0;
  int onehot_err = 0;
  int byte_err = 0;
  int idle_ready_cnt [4];
  int tx_cnt = 0;
  int tx_dur = 0;
  int model_rr = 0;
  logic [3:0] acc_s;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_acc = 1'b0;

  task automatic drive_reqs();
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    v = 4'b0; l = 4'b0; d = 32'b0;
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() > 0) begin
        v[i] = 1'b1;
        l[i] = rq[i][0][8];
        d    = d | (32'(rq[i][0][7:0]) << (8 * i));
      end
    end
    req_valid = v;
    req_last  = l;
    req_data  = d;
  endtask

  // Environment: UART stub, requester handshakes, protocol monitors.
  always begin : env
    @(negedge clock);
    if (!reset_n) begin
      tx_cnt   = 0;
      tx_ready = 1'b1;
    end else if (tx_write_trigger) begin
      trig_id.push_back(grant_id);
      trig_byte.push_back(tx_byte);
      tx_cnt   = (tx_dur > 0) ? tx_dur : int'($urandom_range(6, 2));
      tx_ready = 1'b0;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_ready = 1'b1;
    end
    #1;
    acc_s = req_valid & req_ready;
    if ((req_ready & (req_ready - 4'd1)) != 4'd0) onehot_err++;
    if (req_ready != 4'd0 && req_ready != (4'b0001 << grant_id)) onehot_err++;
    for (int i = 0; i < 4; i++)
      if (req_ready[i] && !req_valid[i]) idle_ready_cnt[i]++;
    if (reset_n && tx_byte !== prev_byte && !prev_acc) byte_err++;
    prev_byte = tx_byte;
    prev_acc  = |acc_s;
    @(posedge clock);
    #1;
    if (reset_n)
      for (int i = 0; i < 4; i++)
        if (acc_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    drive_reqs();
  end

  // Packet-level reference: round robin over non-empty queues; a grant ends
  // on a last byte, on MAX_BURST bytes, or when the holder runs dry (abort).
  task automatic model_run();
    logic [8:0] mq [4][$];
    logic [8:0] e;
    int rr, g, n;
    for (int i = 0; i < 4; i++) mq[i] = rq[i];
    exp_id.delete();
    exp_byte.delete();
    rr = model_rr;
    while (1) begin
      g = -1;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (rr + k) % 4;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      if (g < 0) break;
      n = 0;
      while (1) begin
        e = mq[g].pop_front();
        exp_id.push_back(2'(g));
        exp_byte.push_back(e[7:0]);
        n++;
        if (e[8] || n == MAXB || mq[g].size() == 0) break;
      end
      rr = (g + 1) % 4;
    end
    model_rr = rr;
  endtask

  task automatic clear_logs();
    trig_id.delete();
    trig_byte.delete();
    onehot_err = 0;
    byte_err   = 0;
    for (int i = 0; i < 4; i++) idle_ready_cnt[i] = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) rq[i].delete();
    tx_dur = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2;
    reset_n  = 1'b1;
    model_rr = 0;
    clear_logs();
  endtask

  // Wait until all queues drained and the scheduler idles; ok=0 on budget expiry.
  task automatic wait_idle(output bit ok);
    int stable, cyc;
    stable = 0; cyc = 0;
    while (stable < 4 && cyc < 3000) begin
      @(negedge clock);
      #2;
      if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
          rq[3].size() == 0 && !busy) stable++;
      else stable = 0;
      cyc++;
    end
    ok = (stable >= 4);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) rq[i].push_back({1'b1, 8'(8'h10 + i)});
    @(posedge clock);
    #2;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    total++; if (grant_id !== 2'd0) $display("FAIL rst_grant got %0d want 0", grant_id); else passed++;
    total++; if (tx_byte !== 8'h00) $display("FAIL rst_byte got %h want 00", tx_byte); else passed++;
    total++; if (tx_write_trigger !== 1'b0) $display("FAIL rst_trig got %b want 0", tx_write_trigger); else passed++;
    total++; if (req_ready !== 4'b0000) $display("FAIL rst_ready got %b want 0000 (valid=%b)", req_ready, req_valid); else passed++;
    do_reset();
  endtask

  task automatic test_single_byte();
    bit ok;
    do_reset();
    rq[0].push_back({1'b1, 8'h55});
    model_run();
    wait_idle(ok);
    total++; if (!ok) $display("FAIL single_done got timeout want idle"); else passed++;
    total++; if (trig_id.size() != 1) $display("FAIL single_count got %0d want 1", trig_id.size()); else passed++;
    if (trig_id.size() >= 1) begin
      total++;
      if (trig_id[0] !== 2'd0 || trig_byte[0] !== 8'h55)
        $display("FAIL single_tx got id=%0d byte=%h want id=0 byte=55", trig_id[0], trig_byte[0]);
      else passed++;
    end
    total++; if (busy !== 1'b0 || grant_id !== 2'd0) $display("FAIL single_idle got busy=%b grant=%0d want 0/0", busy, grant_id); else passed++;
    // rr pointer now 1: requester 1 must beat requester 0
    clear_logs();
    rq[0].push_back({1'b1, 8'hC0});
    rq[1].push_back({1'b1, 8'hC1});
    model_run();
    wait_idle(ok);
    total++; if (!ok) $display("FAIL single_rr_done got timeout want idle"); else passed++;
    total++; if (trig_id.size() != exp_id.size()) $display("FAIL single_rr_count got %0d want %0d", trig_id.size(), exp_id.size()); else passed++;
    for (int k = 0; k < exp_id.size() && k < trig_id.size(); k++) begin
      total++;
      if (trig_id[k] !== exp_id[k] || trig_byte[k] !== exp_byte[k])
        $display("FAIL single_rr[%0d] got id=%0d byte=%h want id=%0d byte=%h", k, trig_id[k], trig_byte[k], exp_id[k], exp_byte[k]);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) rq[i].push_back({1'b1, 8'(8'h40 + 16 * r + i)});
    model_run();
    wait_idle(ok);
    total++; if (!ok) $display("FAIL rr_done got timeout want idle"); else passed++;
    total++; if (trig_id.size() != exp_id.size()) $display("FAIL rr_count got %0d want %0d", trig_id.size(), exp_id.size()); else passed++;
    for (int k = 0; k < exp_id.size() && k < trig_id.size(); k++) begin
      total++;
      if (trig_id[k] !== exp_id[k] || trig_byte[k] !== exp_byte[k])
        $display("FAIL rr[%0d] got id=%0d byte=%h want id=%0d byte=%h", k, trig_id[k], trig_byte[k], exp_id[k], exp_byte[k]);
      else passed++;
    end
    total++; if (onehot_err != 0) $display("FAIL rr_onehot got %0d violations want 0", onehot_err); else passed++;
  endtask

  task automatic test_burst();
    bit ok;
    do_reset();
    rq[1].push_back({1'b0, 8'hA1});
    rq[1].push_back({1'b0, 8'hA2});
    rq[1].push_back({1'b1, 8'hA3});
    rq[2].push_back({1'b1, 8'hB2});
    model_run();
    wait_idle(ok);
    total++; if (!ok) $display("FAIL burst_done got timeout want idle"); else passed++;
    total++; if (trig_id.size() != exp_id.size()) $display("FAIL burst_count got %0d want %0d", trig_id.size(), exp_id.size()); else passed++;
    for (int k = 0; k < exp_id.size() && k < trig_id.size(); k++) begin
      total++;
      if (trig_id[k] !== exp_id[k] || trig_byte[k] !== exp_byte[k])
        $display("FAIL burst[%0d] got id=%0d byte=%h want id=%0d byte=%h", k, trig_id[k], trig_byte[k], exp_id[k], exp_byte[k]);
      else passed++;
    end
  endtask

  task automatic test_burst_cap();
    bit ok;
    do_reset();
    rq[2].push_back({1'b1, 8'h20});
    model_run();
    wait_idle(ok);
    clear_logs();
    for (int j = 0; j < 6; j++) rq[3].push_back({1'b0, 8'(8'h30 + j)});
    rq[0].push_back({1'b1, 8'h0A});
    model_run();
    wait_idle(ok);
    total++; if (!ok) $display("FAIL cap_done got timeout want idle"); else passed++;
    total++; if (trig_id.size() != exp_id.size()) $display("FAIL cap_count got %0d want %0d", trig_id.size(), exp_id.size()); else passed++;
    for (int k = 0; k < exp_id.size() && k < trig_id.size(); k++) begin
      total++;
      if (trig_id[k] !== exp_id[k] || trig_byte[k] !== exp_byte[k])
        $display("FAIL cap[%0d] got id=%0d byte=%h want id=%0d byte=%h", k, trig_id[k], trig_byte[k], exp_id[k], exp_byte[k]);
      else passed++;
    end
  endtask

  task automatic test_hold_timeout();
    bit ok;
    do_reset();
    tx_dur = 3;
    rq[1].push_back({1'b0, 8'h71});
    rq[2].push_back({1'b1, 8'h72});
    model_run();
    wait_idle(ok);
    total++; if (!ok) $display("FAIL hold_done got timeout want idle"); else passed++;
    total++; if (trig_id.size() != exp_id.size()) $display("FAIL hold_count got %0d want %0d", trig_id.size(), exp_id.size()); else passed++;
    for (int k = 0; k < exp_id.size() && k < trig_id.size(); k++) begin
      total++;
      if (trig_id[k] !== exp_id[k] || trig_byte[k] !== exp_byte[k])
        $display("FAIL hold[%0d] got id=%0d byte=%h want id=%0d byte=%h", k, trig_id[k], trig_byte[k], exp_id[k], exp_byte[k]);
      else passed++;
    end
    total++; if (idle_ready_cnt[1] != HOLD) $display("FAIL hold_cycles got %0d want %0d", idle_ready_cnt[1], HOLD); else passed++;
    total++; if (byte_err != 0) $display("FAIL hold_byte_stable got %0d changes want 0", byte_err); else passed++;
    tx_dur = 0;
  endtask

  task automatic test_random();
    bit ok;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      clear_logs();
      for (int i = 0; i < 4; i++) begin
        int n;
        n = int'($urandom_range(5, 0));
        for (int j = 0; j < n; j++) rq[i].push_back({($urandom_range(2, 0) == 0), 8'($urandom)});
      end
      model_run();
      wait_idle(ok);
      total++; if (!ok) $display("FAIL rand%0d_done got timeout want idle", it); else passed++;
      total++; if (trig_id.size() != exp_id.size()) $display("FAIL rand%0d_count got %0d want %0d", it, trig_id.size(), exp_id.size()); else passed++;
      for (int k = 0; k < exp_id.size() && k < trig_id.size(); k++) begin
        total++;
        if (trig_id[k] !== exp_id[k] || trig_byte[k] !== exp_byte[k])
          $display("FAIL rand%0d[%0d] got id=%0d byte=%h want id=%0d byte=%h", it, k, trig_id[k], trig_byte[k], exp_id[k], exp_byte[k]);
        else passed++;
      end
      total++; if (onehot_err != 0 || byte_err != 0) $display("FAIL rand%0d_protocol got onehot=%0d byte=%0d want 0/0", it, onehot_err, byte_err); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    do_reset();
    tx_dur = 8;
    rq[0].push_back({1'b1, 8'h3C});
    cyc = 0;
    while (trig_id.size() == 0 && cyc < 200) begin
      @(negedge clock);
      #2;
      cyc++;
    end
    total++; if (trig_id.size() != 1) $display("FAIL rmid_trigger got %0d want 1", trig_id.size()); else passed++;
    repeat (3) @(posedge clock);
    #3;
    total++; if (busy !== 1'b1 || tx_byte !== 8'h3C) $display("FAIL rmid_pre got busy=%b byte=%h want 1/3c", busy, tx_byte); else passed++;
    reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else passed++;
    total++; if (tx_byte !== 8'h00) $display("FAIL rmid_byte got %h want 00", tx_byte); else passed++;
    total++; if (grant_id !== 2'd0 || tx_write_trigger !== 1'b0 || req_ready !== 4'b0)
      $display("FAIL rmid_outs got grant=%0d trig=%b ready=%b want 0/0/0000", grant_id, tx_write_trigger, req_ready); else passed++;
    for (int i = 0; i < 4; i++) rq[i].delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    total++; if (trig_id.size() != 1) $display("FAIL rmid_no_extra got %0d triggers want 1", trig_id.size()); else passed++;
    tx_dur   = 0;
    model_rr = 0;
    clear_logs();
    rq[2].push_back({1'b1, 8'h92});
    model_run();
    wait_idle(ok);
    total++; if (!ok) $display("FAIL rmid_done got timeout want idle"); else passed++;
    total++; if (trig_id.size() != exp_id.size()) $display("FAIL rmid_count got %0d want %0d", trig_id.size(), exp_id.size()); else passed++;
    for (int k = 0; k < exp_id.size() && k < trig_id.size(); k++) begin
      total++;
      if (trig_id[k] !== exp_id[k] || trig_byte[k] !== exp_byte[k])
        $display("FAIL rmid[%0d] got id=%0d byte=%h want id=%0d byte=%h", k, trig_id[k], trig_byte[k], exp_id[k], exp_byte[k]);
      else passed++;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    tx_ready  = 1'b1;
    req_valid = 4'b0;
    req_last  = 4'b0;
    req_data  = 32'b0;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_burst();
    test_burst_cap();
    test_hold_timeout();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got no completion want finish (passed=%0d total=%0d)", passed, total);
    $fatal(1);
  end

endmodule
